// File: rtl/crack_dispatcher_if.sv
// Handshake bundle between the top-level control, the crack-core array and crack_dispatcher.
// The dispatcher connects through the slave modport; control and cores connect through master.
interface crack_dispatcher_if #(
  parameter int NCORES = 4,
  parameter int KEY_W  = 24
);
  logic                      start;
  logic                      stop;
  logic [NCORES-1:0]         core_start;
  logic [NCORES*KEY_W-1:0]   core_key;
  logic [NCORES-1:0]         core_done;
  logic [NCORES-1:0]         core_found;
  logic                      busy;
  logic                      found;
  logic                      exhausted;
  logic [KEY_W-1:0]          key_out;
  logic [KEY_W:0]            keys_tried;

  modport master (
    output start, stop, core_done, core_found,
    input  core_start, core_key, busy, found, exhausted, key_out, keys_tried
  );

  modport slave (
    input  start, stop, core_done, core_found,
    output core_start, core_key, busy, found, exhausted, key_out, keys_tried
  );
endinterface

// File: rtl/crack_dispatcher.sv
// Key-space dispatcher for NCORES ARC4 crack cores: hands out keys 0..KEY_LAST, latches the first match.
// Optional CRACK_DISPATCH_STATS_EN builds the keys_tried verdict counter; otherwise keys_tried reads 0.
module crack_dispatcher #(
  parameter int               NCORES   = 4,
  parameter int               KEY_W    = 24,
  parameter logic [KEY_W-1:0] KEY_LAST = {KEY_W{1'b1}}
) (
  input logic              clk,
  input logic              rst,
  crack_dispatcher_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  localparam logic [KEY_W:0] KEY_END = {1'b0, KEY_LAST};

  state_e                  state_q, state_d;
  logic [NCORES-1:0]       active_q, active_d;
  logic [NCORES-1:0]       core_start_q, core_start_d;
  logic [NCORES*KEY_W-1:0] core_key_q, core_key_d;
  logic                    busy_q, busy_d;
  logic                    found_q, found_d;
  logic                    exhausted_q, exhausted_d;
  logic [KEY_W-1:0]        key_out_q, key_out_d;
  logic [KEY_W:0]          next_key_q, next_key_d;

  logic [NCORES-1:0]       done_v;
  logic                    keys_left;
  logic                    match_hit;
  logic [KEY_W-1:0]        match_key;
  logic                    launch_en;
  logic                    launched;
  logic [KEY_W:0]          launch_key;

  // Verdicts from cores we did not launch (e.g. abandoned by reset) are dropped here.
  assign done_v    = bus.core_done & active_q;
  assign keys_left = (next_key_q <= KEY_END);

  always_comb begin
    match_hit = 1'b0;
    match_key = '0;
    for (int i = 0; i < NCORES; i++) begin
      if (!match_hit && done_v[i] && bus.core_found[i]) begin
        match_hit = 1'b1;
        match_key = core_key_q[i*KEY_W +: KEY_W];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    active_d     = active_q & ~done_v;
    core_start_d = '0;
    core_key_d   = core_key_q;
    found_d      = found_q;
    exhausted_d  = exhausted_q;
    key_out_d    = key_out_q;
    next_key_d   = next_key_q;
    launch_en    = 1'b0;
    launch_key   = next_key_q;
    launched     = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          found_d     = 1'b0;
          exhausted_d = 1'b0;
          key_out_d   = '0;
          next_key_d  = '0;
          launch_key  = '0;
          launch_en   = 1'b1;
          state_d     = S_RUN;
        end
      end
      S_RUN: begin
        // Match outranks stop, stop outranks exhaustion; none of them launch this cycle.
        if (match_hit || bus.stop) begin
          if (match_hit) begin
            found_d   = 1'b1;
            key_out_d = match_key;
          end
          state_d = (active_d == '0) ? S_DONE : S_DRAIN;
        end else if (!keys_left) begin
          if (active_d == '0) begin
            exhausted_d = 1'b1;
            state_d     = S_DONE;
          end
        end else begin
          launch_en = 1'b1;
        end
      end
      S_DRAIN: begin
        if (active_d == '0) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    // A core finishing this cycle is not relaunched until the next one.
    for (int i = 0; i < NCORES; i++) begin
      if (launch_en && !launched && !active_q[i] && !bus.core_done[i]) begin
        launched                     = 1'b1;
        active_d[i]                  = 1'b1;
        core_start_d[i]              = 1'b1;
        core_key_d[i*KEY_W +: KEY_W] = launch_key[KEY_W-1:0];
        next_key_d                   = launch_key + 1'b1;
      end
    end

    busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      active_q     <= '0;
      core_start_q <= '0;
      core_key_q   <= '0;
      busy_q       <= 1'b0;
      found_q      <= 1'b0;
      exhausted_q  <= 1'b0;
      key_out_q    <= '0;
      next_key_q   <= '0;
    end else begin
      state_q      <= state_d;
      active_q     <= active_d;
      core_start_q <= core_start_d;
      core_key_q   <= core_key_d;
      busy_q       <= busy_d;
      found_q      <= found_d;
      exhausted_q  <= exhausted_d;
      key_out_q    <= key_out_d;
      next_key_q   <= next_key_d;
    end
  end

`ifdef CRACK_DISPATCH_STATS_EN
  logic [KEY_W:0] keys_tried_q, keys_tried_d;

  always_comb begin
    keys_tried_d = keys_tried_q;
    if ((state_q == S_IDLE || state_q == S_DONE) && bus.start) begin
      keys_tried_d = '0;
    end else if (state_q == S_RUN || state_q == S_DRAIN) begin
      for (int i = 0; i < NCORES; i++) begin
        keys_tried_d = keys_tried_d + (KEY_W+1)'(done_v[i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) keys_tried_q <= '0;
    else     keys_tried_q <= keys_tried_d;
  end

  assign bus.keys_tried = keys_tried_q;
`else
  assign bus.keys_tried = '0;
`endif

  assign bus.core_start = core_start_q;
  assign bus.core_key   = core_key_q;
  assign bus.busy       = busy_q;
  assign bus.found      = found_q;
  assign bus.exhausted  = exhausted_q;
  assign bus.key_out    = key_out_q;

endmodule

// File: tb/tb_crack_dispatcher.sv
// Scoreboard bench for crack_dispatcher: 4 behavioural cores, key space 0..15, timed reference model.
module tb_crack_dispatcher;
  localparam int NC = 4;
  localparam int KW = 24;
  localparam int KL = 15;
`ifdef CRACK_DISPATCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct { int cyc; int core; int key; } launch_t;
  typedef struct { int cyc; bit found; int key; bit exh; int tried; } res_t;

  logic clk = 1'b0;
  logic rst;

  crack_dispatcher_if #(.NCORES(NC), .KEY_W(KW)) bus();

  crack_dispatcher #(.NCORES(NC), .KEY_W(KW), .KEY_LAST(KW'(KL))) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial forever #5 clk = ~clk;

  launch_t   launch_q[$];
  res_t      res_q[$];
  int        lat[NC] = '{default: 10};
  bit [KL:0] match_mask = '0;
  int        cyc = 0;
  int        n_cmp = 0;
  int        n_err = 0;
  bit        mon_en = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Cores: latency lat[i] from the launch edge to the edge that samples core_done.
  initial begin
    int cnt[NC];
    int ckey[NC];
    logic [NC-1:0] d, f;
    for (int i = 0; i < NC; i++) begin cnt[i] = 0; ckey[i] = 0; end
    bus.core_done  = '0;
    bus.core_found = '0;
    forever begin
      @(posedge clk); #1;
      d = '0;
      f = '0;
      for (int i = 0; i < NC; i++) begin
        if (bus.core_start[i] === 1'b1) begin
          cnt[i]  = lat[i];
          ckey[i] = int'(bus.core_key[i*KW +: KW]);
        end
      end
      for (int i = 0; i < NC; i++) begin
        f[i] = 1'($urandom_range(0, 1));
        if (cnt[i] > 0) begin
          cnt[i]--;
          if (cnt[i] == 0) begin
            d[i] = 1'b1;
            f[i] = (ckey[i] >= 0 && ckey[i] <= KL) ? match_mask[ckey[i]] : 1'b0;
          end
        end else begin
          f[i] = f[i] & d[i];
        end
      end
      bus.core_done  = d;
      bus.core_found = f;
    end
  end

  // Reference: edge-by-edge schedule of key handout from per-core free times and the search rules.
  task automatic run_model(input int base, input int stop_at);
    int ck[NC];
    int done_at[NC];
    int free_at[NC];
    int nk = 0, tried = 0, fkey = 0, end_e = 0;
    bit fnd = 1'b0, halted = 1'b0, exh = 1'b0, any_act;
    launch_t l;
    res_t r;
    for (int i = 0; i < NC; i++) begin ck[i] = -1; done_at[i] = 0; free_at[i] = 0; end
    for (int e = 0; e < 5000; e++) begin
      for (int i = 0; i < NC; i++) begin
        if (ck[i] >= 0 && done_at[i] == e) begin
          tried++;
          if (!halted && match_mask[ck[i]]) begin fnd = 1'b1; fkey = ck[i]; halted = 1'b1; end
          ck[i] = -1;
        end
      end
      if (e == stop_at) halted = 1'b1;
      any_act = 1'b0;
      for (int i = 0; i < NC; i++) if (ck[i] >= 0) any_act = 1'b1;
      if (halted && !any_act) begin end_e = e; break; end
      if (!halted && nk > KL && !any_act) begin exh = 1'b1; end_e = e; break; end
      if (!halted && nk <= KL) begin
        for (int i = 0; i < NC; i++) begin
          if (ck[i] < 0 && free_at[i] <= e) begin
            l.cyc = base + e; l.core = i; l.key = nk;
            launch_q.push_back(l);
            ck[i] = nk; done_at[i] = e + lat[i]; free_at[i] = done_at[i] + 1;
            nk++;
            break;
          end
        end
      end
    end
    r.cyc = base + end_e; r.found = fnd; r.key = fnd ? fkey : 0; r.exh = exh; r.tried = tried;
    res_q.push_back(r);
  endtask

  // Monitor: pops expectations whenever the DUT launches a core or ends a search.
  initial begin
    bit prev_busy = 1'b0;
    launch_t l;
    res_t r;
    int c;
    forever begin
      @(posedge clk); cyc++; #1;
      if (!rst && mon_en) begin
        if (bus.core_start != '0) begin
          chk("launch_onehot", $countones(bus.core_start), 1);
          c = 0;
          for (int i = NC - 1; i >= 0; i--) if (bus.core_start[i]) c = i;
          if (launch_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL unexpected_launch: core %0d key %0d at cycle %0d, required no launch",
                     c, bus.core_key[c*KW +: KW], cyc);
          end else begin
            l = launch_q.pop_front();
            chk("launch_cycle", cyc, l.cyc);
            chk("launch_core", c, l.core);
            chk("launch_key", bus.core_key[c*KW +: KW], l.key);
          end
        end
        if (prev_busy && !bus.busy) begin
          if (res_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL unexpected_done: busy fell at cycle %0d, required no completion", cyc);
          end else begin
            r = res_q.pop_front();
            chk("end_cycle", cyc, r.cyc);
            chk("found", bus.found, r.found);
            chk("key_out", bus.key_out, r.key);
            chk("exhausted", bus.exhausted, r.exh);
            chk("keys_tried", bus.keys_tried, STATS ? r.tried : 0);
          end
        end
      end
      prev_busy = bus.busy;
    end
  end

  task automatic run_search(input int stop_at, input int extra_start);
    int base;
    bit ended = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    base = cyc + 1;
    run_model(base, stop_at);
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_after_start", bus.busy, 1);
    for (int k = 1; k < 4000; k++) begin
      bus.stop  = (k == stop_at);
      bus.start = (k == extra_start);
      if (!bus.busy && k > stop_at && k > extra_start) begin ended = 1'b1; break; end
      @(negedge clk);
    end
    bus.stop  = 1'b0;
    bus.start = 1'b0;
    if (!ended) begin
      n_cmp++; n_err++;
      $display("FAIL search_timeout: busy still %0d, required 0", bus.busy);
    end
    @(negedge clk);
    chk("launch_q_drained", launch_q.size(), 0);
    chk("res_q_drained", res_q.size(), 0);
    launch_q.delete();
    res_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.stop  = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_core_start", bus.core_start, 0);
    chk("rst_core_key", bus.core_key, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_found", bus.found, 0);
    chk("rst_exhausted", bus.exhausted, 0);
    chk("rst_key_out", bus.key_out, 0);
    chk("rst_keys_tried", bus.keys_tried, 0);
    rst       = 1'b0;
    bus.start = 1'b0;

    // Full sweep, with a start pulse during RUN that must be ignored.
    run_search(-1, 5);
    match_mask = '0; match_mask[9] = 1'b1;
    run_search(-1, -1);
    // Keys 5 and 6 finish on cores 1 and 2 in the same cycle.
    lat = '{10, 11, 10, 10};
    match_mask = '0; match_mask[5] = 1'b1; match_mask[6] = 1'b1;
    run_search(-1, -1);
    // Abort after six launches.
    lat = '{default: 10};
    match_mask = '0;
    run_search(13, -1);

    // Reset mid-search, then let abandoned cores report into IDLE.
    mon_en = 1'b0;
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    repeat (10) @(negedge clk);
    chk("midrun_busy", bus.busy, 1);
    rst = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_core_start", bus.core_start, 0);
    chk("midrst_keys_tried", bus.keys_tried, 0);
    repeat (20) @(negedge clk);
    chk("idle_busy", bus.busy, 0);
    chk("idle_found", bus.found, 0);
    chk("idle_keys_tried", bus.keys_tried, 0);
    match_mask = '0; match_mask[12] = 1'b1;
    run_search(-1, -1);

    for (int n = 0; n < 25; n++) begin
      for (int i = 0; i < NC; i++) lat[i] = $urandom_range(1, 12);
      for (int k = 0; k <= KL; k++) match_mask[k] = ($urandom_range(0, 11) == 0);
      run_search(($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 60)) : -1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
